// File: rtl/led_display_row_shifter_if.sv
// Row stream from a row source into the panel shifter: one full rgb row plus
// its panel row address, transferred on valid && ready.
interface led_display_row_shifter_if #(
  parameter int NUM_COL_PIXELS = 64
);
  logic [6*NUM_COL_PIXELS-1:0] row_in;
  logic [3:0]                  row_address_in;
  logic                        row_valid_in;
  logic                        row_ready_out;

  modport master (
    output row_in,
    output row_address_in,
    output row_valid_in,
    input  row_ready_out
  );

  modport slave (
    input  row_in,
    input  row_address_in,
    input  row_valid_in,
    output row_ready_out
  );
endinterface

// File: rtl/led_display_row_shifter.sv
// HUB75 row shifter: one-deep hold register feeding a shift/blank/latch/on sequence.
// Row period NUM_COL_PIXELS*2*BCLK_HALF+BLANK+LATCH+ON cycles; ready drops while the hold register is full.
module led_display_row_shifter #(
  parameter int NUM_COL_PIXELS = 64,
  parameter int BCLK_HALF      = 2,
  parameter int BLANK_CYCLES   = 4,
  parameter int LATCH_CYCLES   = 1,
  parameter int ON_CYCLES      = 64
) (
  input  logic                            clk_in,
  input  logic                            n_reset_in,
  led_display_row_shifter_if.slave        row_if,
  output logic                            bclk_out,
  output logic [2:0]                      rgb_top_out,
  output logic [2:0]                      rgb_bot_out,
  output logic                            latch_out,
  output logic                            blank_out,
  output logic [3:0]                      address_out,
  output logic                            busy_out
);

  localparam int N       = NUM_COL_PIXELS;
  localparam int ROW_W   = 6 * N;
  localparam int MAX_A   = (2 * BCLK_HALF > BLANK_CYCLES) ? 2 * BCLK_HALF : BLANK_CYCLES;
  localparam int MAX_B   = (MAX_A > LATCH_CYCLES) ? MAX_A : LATCH_CYCLES;
  localparam int CNT_MAX = (MAX_B > ON_CYCLES) ? MAX_B : ON_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int COL_W   = (N > 1) ? $clog2(N) : 1;

  localparam logic [CW-1:0]    BCLK_LO_END = CW'(BCLK_HALF - 1);
  localparam logic [CW-1:0]    BCLK_HI_END = CW'(2 * BCLK_HALF - 1);
  localparam logic [CW-1:0]    BLANK_END   = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0]    LATCH_END   = CW'(LATCH_CYCLES - 1);
  localparam logic [CW-1:0]    ON_END      = CW'(ON_CYCLES - 1);
  localparam logic [COL_W-1:0] COL_LAST    = COL_W'(N - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_BLANK,
    ST_LATCH,
    ST_ON
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  shift_q, shift_d;
  logic [ROW_W-1:0]  hold_q, hold_d;
  logic [3:0]        hold_addr_q, hold_addr_d;
  logic [3:0]        row_addr_q, row_addr_d;
  logic              hold_full_q, hold_full_d;
  logic              rst_q;
  logic              bclk_q, bclk_d;
  logic [2:0]        rgb_top_q, rgb_top_d;
  logic [2:0]        rgb_bot_q, rgb_bot_d;
  logic              latch_q, latch_d;
  logic              blank_q, blank_d;
  logic [3:0]        address_q, address_d;
  logic              xfer;
  logic              start;

  assign row_if.row_ready_out = ~hold_full_q & rst_q;
  assign xfer                 = row_if.row_valid_in & row_if.row_ready_out;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    col_d       = col_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_addr_d = hold_addr_q;
    hold_full_d = hold_full_q;
    row_addr_d  = row_addr_q;
    bclk_d      = bclk_q;
    latch_d     = latch_q;
    blank_d     = blank_q;
    address_d   = address_q;
    start       = 1'b0;
    rgb_top_d   = 3'b000;
    rgb_bot_d   = 3'b000;

    if (xfer) begin
      hold_d      = row_if.row_in;
      hold_addr_d = row_if.row_address_in;
      hold_full_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: start = hold_full_q;
      ST_SHIFT: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == BCLK_LO_END) bclk_d = 1'b1;
        if (cnt_q == BCLK_HI_END) begin
          cnt_d  = '0;
          bclk_d = 1'b0;
          if (col_q == '0) begin
            state_d   = ST_BLANK;
            blank_d   = 1'b1;
            address_d = row_addr_q;
          end else begin
            col_d   = col_q - COL_W'(1);
            // Whole-vector shift: bits crossing a field boundary never reach
            // the field MSB within the remaining columns.
            shift_d = shift_q << 1;
          end
        end
      end
      ST_BLANK: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == BLANK_END) begin
          state_d = ST_LATCH;
          cnt_d   = '0;
          latch_d = 1'b1;
        end
      end
      ST_LATCH: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LATCH_END) begin
          state_d = ST_ON;
          cnt_d   = '0;
          latch_d = 1'b0;
          blank_d = 1'b0;
        end
      end
      ST_ON: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == ON_END) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          // A waiting row starts straight away so back-to-back rows
          // do not pay an extra IDLE cycle.
          start   = hold_full_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (start) begin
      state_d     = ST_SHIFT;
      cnt_d       = '0;
      col_d       = COL_LAST;
      shift_d     = hold_q;
      row_addr_d  = hold_addr_q;
      hold_full_d = 1'b0;
      bclk_d      = 1'b0;
      blank_d     = 1'b0;
    end

    if (state_d == ST_SHIFT) begin
      rgb_top_d = {shift_d[4*N-1], shift_d[5*N-1], shift_d[6*N-1]};
      rgb_bot_d = {shift_d[N-1],   shift_d[2*N-1], shift_d[3*N-1]};
    end
  end

  always_ff @(posedge clk_in) begin
    rst_q <= n_reset_in;
    if (!n_reset_in) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      col_q       <= '0;
      hold_full_q <= 1'b0;
      bclk_q      <= 1'b0;
      rgb_top_q   <= 3'b000;
      rgb_bot_q   <= 3'b000;
      latch_q     <= 1'b0;
      blank_q     <= 1'b1;
      address_q   <= 4'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      col_q       <= col_d;
      hold_full_q <= hold_full_d;
      bclk_q      <= bclk_d;
      rgb_top_q   <= rgb_top_d;
      rgb_bot_q   <= rgb_bot_d;
      latch_q     <= latch_d;
      blank_q     <= blank_d;
      address_q   <= address_d;
    end
  end

  always_ff @(posedge clk_in) begin
    shift_q     <= shift_d;
    hold_q      <= hold_d;
    hold_addr_q <= hold_addr_d;
    row_addr_q  <= row_addr_d;
  end

  assign bclk_out    = bclk_q;
  assign rgb_top_out = rgb_top_q;
  assign rgb_bot_out = rgb_bot_q;
  assign latch_out   = latch_q;
  assign blank_out   = blank_q;
  assign address_out = address_q;
  assign busy_out    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_led_display_row_shifter.sv
// Directed bench for led_display_row_shifter: rows go into a scoreboard on
// acceptance and are compared against what the panel pins shifted out.
module tb_led_display_row_shifter;
  localparam int N = 64;
  typedef logic [6*N-1:0] row_t;

  typedef struct {
    row_t       row;
    logic [3:0] addr;
  } exp_t;

  typedef struct {
    logic [N-1:0] tr, tg, tb, br, bg, bb;
    logic [3:0]   addr;
    int           edges;
    int           blank_run;
    int           latch_w;
    int           latch_t;
  } obs_t;

  logic       clk_in = 1'b0;
  logic       n_reset_in;
  logic       bclk_out, latch_out, blank_out, busy_out;
  logic [2:0] rgb_top_out, rgb_bot_out;
  logic [3:0] address_out;

  int errors = 0;
  int checks = 0;

  exp_t exp_q[$];
  obs_t obs_q[$];

  led_display_row_shifter_if #(.NUM_COL_PIXELS(N)) rif ();

  led_display_row_shifter #(
    .NUM_COL_PIXELS(N), .BCLK_HALF(2), .BLANK_CYCLES(4), .LATCH_CYCLES(1), .ON_CYCLES(64)
  ) dut (
    .clk_in      (clk_in),
    .n_reset_in  (n_reset_in),
    .row_if      (rif.slave),
    .bclk_out    (bclk_out),
    .rgb_top_out (rgb_top_out),
    .rgb_bot_out (rgb_bot_out),
    .latch_out   (latch_out),
    .blank_out   (blank_out),
    .address_out (address_out),
    .busy_out    (busy_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic obs_t obs_zero();
    obs_t o;
    o.tr = '0; o.tg = '0; o.tb = '0; o.br = '0; o.bg = '0; o.bb = '0;
    o.addr = '0; o.edges = 0; o.blank_run = 0; o.latch_w = 0; o.latch_t = 0;
    return o;
  endfunction

  // Pin monitor: rebuilds each shifted row from samples at bclk rising edges.
  obs_t cur;
  int   mon_edges = 0;
  int   cyc = 0;
  int   blank_run = 0;
  int   latch_w = 0;
  logic prev_bclk = 1'b0;
  logic prev_latch = 1'b0;

  always @(negedge clk_in) begin
    cyc++;
    if (n_reset_in !== 1'b1) begin
      cur       = obs_zero();
      mon_edges = 0;
      blank_run = 0;
      latch_w   = 0;
    end else begin
      if (bclk_out && !prev_bclk) begin
        if (mon_edges < N) begin
          cur.tr[N-1-mon_edges] = rgb_top_out[0];
          cur.tg[N-1-mon_edges] = rgb_top_out[1];
          cur.tb[N-1-mon_edges] = rgb_top_out[2];
          cur.br[N-1-mon_edges] = rgb_bot_out[0];
          cur.bg[N-1-mon_edges] = rgb_bot_out[1];
          cur.bb[N-1-mon_edges] = rgb_bot_out[2];
        end
        mon_edges++;
      end
      if (latch_out) begin
        if (!prev_latch) begin
          cur.blank_run = blank_run;
          cur.latch_t   = cyc;
          cur.addr      = address_out;
        end
        latch_w++;
      end else if (prev_latch) begin
        cur.latch_w = latch_w;
        cur.edges   = mon_edges;
        obs_q.push_back(cur);
        cur       = obs_zero();
        mon_edges = 0;
        latch_w   = 0;
      end
      if (blank_out && !latch_out) blank_run++;
      else if (!blank_out) blank_run = 0;
    end
    prev_bclk  = bclk_out;
    prev_latch = latch_out;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #2;
  endtask

  task automatic send(input row_t r, input logic [3:0] a, input string tag);
    int   t;
    bit   ok;
    exp_t e;
    t  = 0;
    ok = 0;
    rif.row_in         = r;
    rif.row_address_in = a;
    rif.row_valid_in   = 1'b1;
    while (!ok && t < 2000) begin
      if (rif.row_ready_out === 1'b1) ok = 1;
      step();
      t++;
    end
    chk({tag, "_accepted"}, 64'(ok), 64'd1);
    if (ok) begin
      e.row  = r;
      e.addr = a;
      exp_q.push_back(e);
      chk({tag, "_ready_low_after_accept"}, 64'(rif.row_ready_out), 64'd0);
    end
  endtask

  task automatic check_next_row(input string tag, output int lt);
    int   t;
    obs_t o;
    exp_t e;
    t  = 0;
    lt = 0;
    while (obs_q.size() == 0 && t < 1500) begin
      step();
      t++;
    end
    chk({tag, "_row_seen"}, 64'(obs_q.size() > 0), 64'd1);
    if (obs_q.size() == 0) return;
    o = obs_q.pop_front();
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else begin
      e.row  = '0;
      e.addr = '0;
    end
    chk({tag, "_edges"},     64'(o.edges), 64'(N));
    chk({tag, "_top_red"},   o.tr, e.row[6*N-1 -: N]);
    chk({tag, "_top_green"}, o.tg, e.row[5*N-1 -: N]);
    chk({tag, "_top_blue"},  o.tb, e.row[4*N-1 -: N]);
    chk({tag, "_bot_red"},   o.br, e.row[3*N-1 -: N]);
    chk({tag, "_bot_green"}, o.bg, e.row[2*N-1 -: N]);
    chk({tag, "_bot_blue"},  o.bb, e.row[N-1 -: N]);
    chk({tag, "_address"},   64'(o.addr), 64'(e.addr));
    chk({tag, "_blank_run"}, 64'(o.blank_run), 64'd4);
    chk({tag, "_latch_w"},   64'(o.latch_w), 64'd1);
    lt = o.latch_t;
  endtask

  function automatic row_t rand_row();
    row_t r;
    for (int i = 0; i < 12; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  initial begin
    row_t         r;
    logic [N-1:0] ones;
    logic [N-1:0] zeros;
    logic [N-1:0] gpat;
    int           lt0, lt1, lt2;
    int           bad;
    int           t;

    ones  = '1;
    zeros = '0;
    gpat  = 64'h8000_0000_0000_0001;

    n_reset_in         = 1'b0;
    rif.row_in         = '0;
    rif.row_address_in = '0;
    rif.row_valid_in   = 1'b0;

    // Reset and release.
    repeat (3) step();
    chk("rst_blank",   64'(blank_out),   64'd1);
    chk("rst_address", 64'(address_out), 64'd0);
    chk("rst_bclk",    64'(bclk_out),    64'd0);
    chk("rst_busy",    64'(busy_out),    64'd0);
    chk("rst_latch",   64'(latch_out),   64'd0);
    chk("rst_rgb",     64'({rgb_top_out, rgb_bot_out}), 64'd0);
    chk("rst_ready",   64'(rif.row_ready_out), 64'd0);
    n_reset_in = 1'b1;
    chk("rel_ready_before_edge", 64'(rif.row_ready_out), 64'd0);
    step();
    chk("rel_ready",   64'(rif.row_ready_out), 64'd1);
    chk("rel_blank",   64'(blank_out), 64'd1);
    chk("rel_busy",    64'(busy_out),  64'd0);

    // Solid red, address 5.
    send({ones, zeros, zeros, ones, zeros, zeros}, 4'd5, "red");
    rif.row_valid_in = 1'b0;
    check_next_row("red", lt0);
    bad = 0;
    for (int i = 0; i < 63; i++) begin
      if (blank_out !== 1'b0) bad++;
      step();
    end
    chk("red_on_blank_low", 64'(bad), 64'd0);
    chk("red_address_held", 64'(address_out), 64'd5);

    // Single green bits at first and last column.
    send({zeros, gpat, zeros, zeros, zeros, zeros}, 4'd10, "green");
    rif.row_valid_in = 1'b0;
    check_next_row("green", lt0);

    // Three rows with valid held continuously.
    send(rand_row(), 4'd0, "b2b0");
    send(rand_row(), 4'd1, "b2b1");
    send(rand_row(), 4'd2, "b2b2");
    rif.row_valid_in = 1'b0;
    check_next_row("b2b0", lt0);
    check_next_row("b2b1", lt1);
    check_next_row("b2b2", lt2);
    chk("b2b_latch_gap_01", 64'(lt1 - lt0), 64'd325);
    chk("b2b_latch_gap_12", 64'(lt2 - lt1), 64'd325);

    // Valid with hold full: no capture, changing data ignored.
    send(rand_row(), 4'd7, "hf_d");
    send(rand_row(), 4'd8, "hf_e");
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      rif.row_in         = rand_row();
      rif.row_address_in = 4'(i);
      if (rif.row_ready_out !== 1'b0) bad++;
      step();
    end
    chk("hf_ready_low_while_full", 64'(bad), 64'd0);
    rif.row_valid_in = 1'b0;
    check_next_row("hf_d", lt0);
    check_next_row("hf_e", lt1);
    repeat (400) step();
    chk("hf_no_extra_row", 64'(obs_q.size()), 64'd0);

    // Reset pulse in the middle of a shift.
    send(rand_row(), 4'd3, "abort");
    rif.row_valid_in = 1'b0;
    t = 0;
    while (mon_edges < 30 && t < 1000) begin
      step();
      t++;
    end
    chk("abort_reached_edge30", 64'(mon_edges >= 30), 64'd1);
    n_reset_in = 1'b0;
    step();
    n_reset_in = 1'b1;
    chk("abort_blank", 64'(blank_out), 64'd1);
    chk("abort_bclk",  64'(bclk_out),  64'd0);
    chk("abort_busy",  64'(busy_out),  64'd0);
    chk("abort_latch", 64'(latch_out), 64'd0);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    repeat (400) step();
    chk("abort_no_latch", 64'(obs_q.size()), 64'd0);
    send(rand_row(), 4'd9, "after_abort");
    rif.row_valid_in = 1'b0;
    check_next_row("after_abort", lt0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
